// File: rtl/fpu_exec_dispatcher_pkg.sv
// Shared types for the FPU exec dispatcher: FSM state, FPU opcode numbers, request bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fpu_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  // FPU opcode numbers as seen on inst_num
  localparam logic [5:0] ABS_S   = 6'd54;
  localparam logic [5:0] NEG_S   = 6'd55;
  localparam logic [5:0] ADD_S   = 6'd56;
  localparam logic [5:0] SUB_S   = 6'd57;
  localparam logic [5:0] MUL_S   = 6'd58;
  localparam logic [5:0] DIV_S   = 6'd59;
  localparam logic [5:0] CVT_S_W = 6'd60;
  localparam logic [5:0] CVT_W_S = 6'd61;
  localparam logic [5:0] SQRT_S  = 6'd62;

  typedef struct packed {
    logic [5:0]  inst_num;
    logic [31:0] fs;
    logic [31:0] ft;
    logic [4:0]  dest;
  } req_t;

  function automatic logic inst_in_range(input logic [5:0] inst,
                                         input logic [5:0] lo,
                                         input logic [5:0] hi);
    return (inst >= lo) && (inst <= hi);
  endfunction

endpackage

// File: rtl/fpu_exec_dispatcher_if.sv
// Handshake bundle between issue stage, dispatcher, exec element and writeback.
// Ports: req_* (issue -> dispatcher, valid/ready), elem_* (dispatcher <-> exec element),
//        res_* (dispatcher -> writeback, valid/ready). master = dispatcher, slave = surroundings.
interface fpu_exec_dispatcher_if;

  // issue side
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_inst_num;
  logic [31:0] req_fs;
  logic [31:0] req_ft;
  logic [4:0]  req_dest;

  // exec element side
  logic        elem_reset;
  logic [5:0]  elem_inst_num;
  logic [31:0] elem_fs;
  logic [31:0] elem_ft;
  logic        elem_completed;
  logic [31:0] elem_out;

  // writeback side
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_dest;
  logic        res_error;

  modport master (
    input  req_valid, req_inst_num, req_fs, req_ft, req_dest,
    output req_ready,
    output elem_reset, elem_inst_num, elem_fs, elem_ft,
    input  elem_completed, elem_out,
    output res_valid, res_data, res_dest, res_error,
    input  res_ready
  );

  modport slave (
    output req_valid, req_inst_num, req_fs, req_ft, req_dest,
    input  req_ready,
    input  elem_reset, elem_inst_num, elem_fs, elem_ft,
    output elem_completed, elem_out,
    input  res_valid, res_data, res_dest, res_error,
    output res_ready
  );

endinterface

// File: rtl/fpu_exec_dispatcher.sv
// Dispatches one FPU op to the exec element: latch operands, hold element reset, wait, return result.
// Latency: legal op = ARM_CYCLES + element time + 1 cycles; illegal op = 1 cycle after accept.
// Backpressure: one op in flight; req_ready low from accept until the result handshake completes.
// Ports: clk, reset (sync, active-high); bus = master side of fpu_exec_dispatcher_if.
module fpu_exec_dispatcher
  import fpu_dispatch_pkg::*;
#(
  parameter int ARM_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int INST_MIN       = 54,
  parameter int INST_MAX       = 62
) (
  input  logic                  clk,
  input  logic                  reset,
  fpu_exec_dispatcher_if.master bus
);

  localparam int AW = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [AW-1:0] ARM_LAST = AW'(ARM_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0]    INST_LO  = 6'(INST_MIN);
  localparam logic [5:0]    INST_HI  = 6'(INST_MAX);

  state_e        state_q;
  logic [AW-1:0] arm_cnt_q;
  logic [TW-1:0] wd_cnt_q;
  req_t          op_q;
  logic          req_ready_q;
  logic          elem_reset_q;
  logic          res_valid_q;
  logic [31:0]   res_data_q;
  logic          res_error_q;

  logic accept;
  logic legal;

  assign accept = bus.req_valid && req_ready_q;
  assign legal  = inst_in_range(bus.req_inst_num, INST_LO, INST_HI);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      arm_cnt_q    <= '0;
      wd_cnt_q     <= '0;
      op_q         <= '0;
      req_ready_q  <= 1'b0;
      elem_reset_q <= 1'b1;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_error_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q  <= 1'b1;
          elem_reset_q <= 1'b1;
          if (accept) begin
            op_q        <= '{inst_num: bus.req_inst_num, fs: bus.req_fs,
                             ft: bus.req_ft, dest: bus.req_dest};
            req_ready_q <= 1'b0;
            arm_cnt_q   <= '0;
            if (!legal) begin
              // Illegal opcode never reaches the element: report straight away.
              state_q     <= DONE;
              res_valid_q <= 1'b1;
              res_data_q  <= '0;
              res_error_q <= 1'b1;
            end else begin
              state_q <= ARM;
            end
          end
        end

        ARM: begin
          // completed is not looked at here; the element is still held in reset.
          if (arm_cnt_q == ARM_LAST) begin
            state_q      <= WAIT;
            elem_reset_q <= 1'b0;
            wd_cnt_q     <= '0;
          end else begin
            arm_cnt_q <= arm_cnt_q + 1'b1;
          end
        end

        WAIT: begin
          // Completion is checked first so it wins over a coincident timeout.
          if (bus.elem_completed) begin
            state_q      <= DONE;
            elem_reset_q <= 1'b1;
            res_valid_q  <= 1'b1;
            res_data_q   <= bus.elem_out;
            res_error_q  <= 1'b0;
          end else if (wd_cnt_q == TO_LAST) begin
            state_q      <= DONE;
            elem_reset_q <= 1'b1;
            res_valid_q  <= 1'b1;
            res_data_q   <= '0;
            res_error_q  <= 1'b1;
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
        end

        DONE: begin
          if (bus.res_ready) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.elem_reset    = elem_reset_q;
  assign bus.elem_inst_num = op_q.inst_num;
  assign bus.elem_fs       = op_q.fs;
  assign bus.elem_ft       = op_q.ft;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_data      = res_data_q;
  assign bus.res_dest      = op_q.dest;
  assign bus.res_error     = res_error_q;

endmodule

// File: tb/tb_fpu_exec_dispatcher.sv
// Bench for fpu_exec_dispatcher with a behavioural exec element (fixed-latency or hung).
// Expected results queued at issue time, compared when the result handshake is observed.
module tb_fpu_exec_dispatcher;
  import fpu_dispatch_pkg::*;

  localparam int ARM_C = 2;
  localparam int TO_C  = 8;
  localparam int ELEM_LAT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fpu_exec_dispatcher_if bus();

  fpu_exec_dispatcher #(
    .ARM_CYCLES(ARM_C), .TIMEOUT_CYCLES(TO_C), .INST_MIN(54), .INST_MAX(62)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // ---------------- behavioural exec element ----------------
  logic elem_hang;
  int   elem_cnt;

  function automatic logic [31:0] elem_calc(input logic [5:0] inst,
                                            input logic [31:0] fs, input logic [31:0] ft);
    logic [31:0] r;
    r = 32'h0;
    case (inst)
      ABS_S:   r = fs & 32'h7fffffff;
      NEG_S:   r = fs ^ 32'h80000000;
      ADD_S:   if (fs == 32'h4048f5c3 && ft == 32'h411ffbe7) r = 32'h41523958;
      MUL_S:   if (fs == 32'h4048f5c3 && ft == 32'h411ffbe7) r = 32'h41fb2cc5;
      DIV_S:   if (fs == 32'h4048f5c3 && ft == 32'h411ffbe7) r = 32'h3ea0c8ba;
      CVT_S_W: if (fs == 32'd1234567) r = 32'h4996b438;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.elem_reset) begin
      elem_cnt           <= 0;
      bus.elem_completed <= 1'b0;
      bus.elem_out       <= 32'h0;
    end else if (!elem_hang) begin
      if (elem_cnt == ELEM_LAT) begin
        bus.elem_completed <= 1'b1;
        bus.elem_out       <= elem_calc(bus.elem_inst_num, bus.elem_fs, bus.elem_ft);
      end else begin
        elem_cnt <= elem_cnt + 1;
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  dest;
    logic        err;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one op at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [5:0] inst, input logic [31:0] fs, input logic [31:0] ft,
                       input logic [4:0] dest, input logic [31:0] exp_d, input logic exp_e);
    int t;
    exp_t e;
    t = 0;
    while (!bus.req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("req_ready_before_issue", 32'(bus.req_ready), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_inst_num = inst;
    bus.req_fs       = fs;
    bus.req_ft       = ft;
    bus.req_dest     = dest;
    e.data = exp_d;
    e.dest = dest;
    e.err  = exp_e;
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("req_ready_after_accept", 32'(bus.req_ready), 32'd0);
  endtask

  // Waits for res_valid (n = negedges waited), compares it to the scoreboard head,
  // then lets the handshake complete (res_ready must already be 1).
  task automatic take_result(input int budget, output int n, output logic prev_cmpl);
    exp_t e;
    n = 0;
    prev_cmpl = 1'b0;
    while (!bus.res_valid && n < budget) begin
      prev_cmpl = bus.elem_completed;
      @(negedge clk);
      n++;
    end
    check("res_valid_seen", 32'(bus.res_valid), 32'd1);
    check("req_ready_in_done", 32'(bus.req_ready), 32'd0);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("res_data", bus.res_data, e.data);
      check("res_dest", 32'(bus.res_dest), 32'(e.dest));
      check("res_error", 32'(bus.res_error), 32'(e.err));
    end
    @(negedge clk);
    check("res_valid_dropped", 32'(bus.res_valid), 32'd0);
    check("req_ready_back", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n;
    logic pc;

    reset            = 1'b1;
    elem_hang        = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_inst_num = 6'd0;
    bus.req_fs       = 32'h0;
    bus.req_ft       = 32'h0;
    bus.req_dest     = 5'd0;
    bus.res_ready    = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_elem_reset", 32'(bus.elem_reset), 32'd1);
    check("rst_res_data", bus.res_data, 32'h0);
    check("rst_res_error", 32'(bus.res_error), 32'd0);
    check("rst_elem_fs", bus.elem_fs, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

    // ADD.S with arming-period timing
    issue(ADD_S, 32'h4048f5c3, 32'h411ffbe7, 5'd3, 32'h41523958, 1'b0);
    check("add_elem_inst", 32'(bus.elem_inst_num), 32'(ADD_S));
    check("add_elem_fs", bus.elem_fs, 32'h4048f5c3);
    check("add_elem_ft", bus.elem_ft, 32'h411ffbe7);
    check("add_arm_reset_1", 32'(bus.elem_reset), 32'd1);
    @(negedge clk);
    check("add_arm_reset_2", 32'(bus.elem_reset), 32'd1);
    @(negedge clk);
    check("add_reset_released", 32'(bus.elem_reset), 32'd0);
    take_result(40, n, pc);
    check("add_cmpl_before_valid", 32'(pc), 32'd1);

    // back-to-back DIV.S then MUL.S
    issue(DIV_S, 32'h4048f5c3, 32'h411ffbe7, 5'd7, 32'h3ea0c8ba, 1'b0);
    take_result(40, n, pc);
    issue(MUL_S, 32'h4048f5c3, 32'h411ffbe7, 5'd8, 32'h41fb2cc5, 1'b0);
    take_result(40, n, pc);

    // illegal opcode
    issue(6'd12, 32'h11111111, 32'h22222222, 5'd9, 32'h0, 1'b1);
    check("illegal_elem_reset", 32'(bus.elem_reset), 32'd1);
    take_result(40, n, pc);
    check("illegal_latency", 32'(n), 32'd0);
    check("illegal_elem_reset_after", 32'(bus.elem_reset), 32'd1);

    // watchdog timeout with a hung element
    elem_hang = 1'b1;
    issue(SQRT_S, 32'h40800000, 32'h0, 5'd4, 32'h0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("to_reset_released", 32'(bus.elem_reset), 32'd0);
    take_result(40, n, pc);
    check("to_latency", 32'(n), 32'(TO_C));
    check("to_elem_rereset", 32'(bus.elem_reset), 32'd1);
    elem_hang = 1'b0;

    // backpressure on the result
    bus.res_ready = 1'b0;
    issue(NEG_S, 32'h7fffffff, 32'h0, 5'd12, 32'hffffffff, 1'b0);
    n = 0;
    while (!bus.res_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", 32'(bus.res_valid), 32'd1);
      check("bp_data_held", bus.res_data, 32'hffffffff);
      check("bp_dest_held", 32'(bus.res_dest), 32'd12);
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    take_result(40, n, pc);
    check("bp_accept_immediate", 32'(n), 32'd0);

    // reset while waiting on a hung element
    elem_hang = 1'b1;
    issue(ADD_S, 32'h4048f5c3, 32'h411ffbe7, 5'd5, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("midrst_in_wait", 32'(bus.elem_reset), 32'd0);
    reset = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    reset = 1'b0;
    elem_hang = 1'b0;
    check("midrst_res_valid", 32'(bus.res_valid), 32'd0);
    check("midrst_elem_reset", 32'(bus.elem_reset), 32'd1);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("midrst_res_valid_2", 32'(bus.res_valid), 32'd0);
    issue(CVT_S_W, 32'd1234567, 32'h0, 5'd1, 32'h4996b438, 1'b0);
    take_result(40, n, pc);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpu_exec_dispatcher.md
Name: fpu_exec_dispatcher

Overview:
Initiator side of the FPU exec-element protocol. It accepts one FPU operation from the issue stage over a valid/ready handshake and latches the operands. It then drives the exec element's operand inputs and holds the element's `reset` high for a fixed arming period. After that it releases `reset`, waits for `completed`, and returns `out` to writeback over a second valid/ready handshake. It sits between decode/issue and FpuAluExecElement, and adds an illegal-opcode check and a watchdog timeout.

Parameters:
- ARM_CYCLES, 2, cycles `elem_reset` is held high after accept, before release (min 1).
- TIMEOUT_CYCLES, 64, max cycles in WAIT before the operation is aborted with an error.
- INST_MIN, 54, lowest legal FPU `inst_num` (ABS.S).
- INST_MAX, 62, highest legal FPU `inst_num` (SQRT.S).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  issue stage presents an op
- req_ready  out  1  dispatcher can accept
- req_inst_num  in  6  FPU opcode number
- req_fs  in  32  operand fs
- req_ft  in  32  operand ft
- req_dest  in  5  destination FP register
- elem_reset  out  1  drives exec element `reset`
- elem_inst_num  out  6  drives element `inst_num`
- elem_fs  out  32  drives element `fs`
- elem_ft  out  32  drives element `ft`
- elem_completed  in  1  element `completed`
- elem_out  in  32  element `out`
- res_valid  out  1  result available
- res_ready  in  1  writeback accepts the result
- res_data  out  32  result value
- res_dest  out  5  destination register
- res_error  out  1  1 = illegal opcode or timeout; res_data is 0

Behaviour:
- Clocking and reset:
  - One clock; `reset` is synchronous and active-high.
  - On reset: state=IDLE, req_ready=0 during reset then 1, res_valid=0, res_data=0, res_dest=0, res_error=0, elem_reset=1, elem_inst_num/fs/ft=0, counters=0.
- States: IDLE, ARM, WAIT, DONE.
- IDLE:
  - req_ready=1, elem_reset=1.
  - Accept occurs on the edge where req_valid&&req_ready.
  - On accept, latch inst_num/fs/ft/dest into operand registers; `elem_*` outputs reflect these registers from the next cycle.
  - If inst_num is outside [INST_MIN, INST_MAX]: go to DONE with res_error=1, res_data=0. The element is never released.
  - Otherwise go to ARM with arm counter=0.
- ARM:
  - req_ready=0, elem_reset=1, operands stable.
  - Stay exactly ARM_CYCLES cycles, then go to WAIT. elem_completed is ignored in this state.
- WAIT:
  - elem_reset=0, operands stable.
  - Watchdog counter starts at 0 on entry and increments each cycle.
  - If elem_completed=1 is sampled: capture elem_out into res_data, res_error=0, go to DONE.
  - Else if the counter reaches TIMEOUT_CYCLES-1: res_data=0, res_error=1, go to DONE.
  - If completion and timeout occur in the same cycle, completion wins.
- DONE:
  - res_valid=1, elem_reset=1 (element re-held), req_ready=0.
  - res_data/res_dest/res_error stay stable while res_valid=1 and res_ready=0.
  - When res_valid&&res_ready: res_valid drops next cycle and state goes to IDLE. No accept happens in the same cycle (req_ready=0 in DONE).
- Latency:
  - Normal op: accept at edge 0; elem_reset falls after ARM_CYCLES edges; res_valid rises one cycle after the cycle completed is sampled.
  - Illegal op: res_valid one cycle after accept.
- Throughput: one op in flight; no queueing.
- Reset mid-operation: abandon the op from any state, back to IDLE, no result emitted, elem_reset=1.
- The element's `completed` must be low while its reset is held. The dispatcher relies on this and samples completed only in WAIT.
- Fixed port widths: inst_num 6 bits, operands/result 32 bits, dest 5 bits. Counters are sized by $clog2 of their parameter.

Decomposition:
- Package fpu_dispatch_pkg:
  - state enum (IDLE, ARM, WAIT, DONE);
  - opcode constants (ABS_S=54, NEG_S=55, ADD_S=56, SUB_S=57, MUL_S=58, DIV_S=59, CVT_S_W=60, CVT_W_S=61, SQRT_S=62);
  - packed request struct {inst_num, fs, ft, dest}.
- No sub-module. Optional sub-module fpu_watchdog_counter (load/enable/expire) if reused elsewhere.

Test Plan:
- ADD.S: req inst=56, fs=4048f5c3, ft=411ffbe7, dest=3, with the real FpuAluExecElement -> elem_reset high exactly 2 cycles after accept, then res_valid with res_data=41523958, res_dest=3, res_error=0.
- Back-to-back DIV.S then MUL.S with the same operands -> results 3ea0c8ba then 41fb2cc5 in order. req_ready=0 from accept until the DONE handshake.
- Illegal inst=12 -> res_valid after 1 cycle, res_error=1, res_data=0; elem_reset never falls.
- Stub element that never completes, TIMEOUT_CYCLES=8 -> res_error=1 exactly 8 cycles after elem_reset falls; elem_reset high again.
- Backpressure: hold res_ready=0 for 5 cycles on NEG.S fs=7fffffff -> res_data=ffffffff held stable throughout; accepted on the 6th cycle.
- Assert reset during WAIT -> next cycle IDLE, res_valid=0, elem_reset=1; a following CVT.S.W fs=1234567 returns 4996b438.
